// File: rtl/imu_pkg.sv
// Shared IMU definitions: scheduler state encoding and default channel geometry
// used across the IMU source, filter and packer blocks.
package imu_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } imu_state_e;

    localparam int IMU_WIDTH  = 16;
    localparam int IMU_NUM_CH = 3;
    localparam int IMU_CH_W   = 2;

endpackage

// File: rtl/imu_tick_divider.sv
// Sample-rate divider: one-cycle tick every DIV clocks while enabled;
// the counter is parked at zero whenever enable is low.
module imu_tick_divider #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!enable || div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = enable && (div_cnt == LAST);

endmodule

// File: rtl/imu_frame_scheduler.sv
// Snapshots all IMU channels on each sample tick and serialises the enabled ones
// onto a valid/ready stream tagged with channel ID and end-of-frame.
module imu_frame_scheduler
    import imu_pkg::*;
#(
    parameter int WIDTH  = IMU_WIDTH,
    parameter int NUM_CH = IMU_NUM_CH,
    parameter int CH_W   = IMU_CH_W,
    parameter int DIV    = 100,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic [NUM_CH*WIDTH-1:0] ch_samples,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic [CH_W-1:0]         m_ch,
    output logic                    m_last,
    output logic                    busy,
    output logic [CNT_W-1:0]        overrun_cnt
);

    imu_state_e        state, state_n;
    logic              tick;
    logic              capture;
    logic [CH_W-1:0]   idx, idx_n;
    logic [NUM_CH-1:0] mask;
    logic [WIDTH-1:0]  snapshot [NUM_CH];
    logic [WIDTH-1:0]  samples_in [NUM_CH];
    logic              valid_n, last_n, busy_n;
    logic [WIDTH-1:0]  data_n;

    imu_tick_divider #(.DIV(DIV)) u_tick_divider (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .tick   (tick)
    );

    // Lowest set bit of m at or above position start (0 when none).
    function automatic logic [CH_W-1:0] lowest_from(input logic [NUM_CH-1:0] m, input int start);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i >= start && m[i]) r = CH_W'(i);
        end
        return r;
    endfunction

    function automatic logic any_from(input logic [NUM_CH-1:0] m, input int start);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i >= start && m[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            samples_in[i] = ch_samples[i*WIDTH +: WIDTH];
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        valid_n = m_valid;
        data_n  = m_data;
        last_n  = m_last;
        busy_n  = busy;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (tick && ch_en != '0) begin
                    capture = 1'b1;
                    state_n = SEND;
                    idx_n   = lowest_from(ch_en, 0);
                    data_n  = samples_in[idx_n];
                    last_n  = !any_from(ch_en, int'(idx_n) + 1);
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            SEND: begin
                if (m_ready) begin
                    if (m_last) begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        busy_n  = 1'b0;
                    end else begin
                        idx_n  = lowest_from(mask, int'(idx) + 1);
                        data_n = snapshot[idx_n];
                        last_n = !any_from(mask, int'(idx_n) + 1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: the snapshot array is small and must read back as zero after reset, so it is reset explicitly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx         <= '0;
            mask        <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_last      <= 1'b0;
            busy        <= 1'b0;
            overrun_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                snapshot[i] <= '0;
            end
        end else begin
            idx     <= idx_n;
            m_valid <= valid_n;
            m_data  <= data_n;
            m_last  <= last_n;
            busy    <= busy_n;
            if (capture) begin
                mask <= ch_en;
                for (int i = 0; i < NUM_CH; i++) begin
                    snapshot[i] <= samples_in[i];
                end
            end
            // A tick arriving while a frame drains, even on its last handshake, is dropped.
            if (tick && state == SEND && !(&overrun_cnt)) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end
        end
    end

    assign m_ch = idx;

endmodule

// File: tb/tb_imu_frame_scheduler.sv
// Directed bench for imu_frame_scheduler with DIV=8, NUM_CH=3; a second instance
// with a 2-bit overrun counter covers saturation.
module tb_imu_frame_scheduler;

    localparam int WIDTH  = 16;
    localparam int NUM_CH = 3;
    localparam int CH_W   = 2;
    localparam int DIV    = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    enable;
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH*WIDTH-1:0] ch_samples;
    logic                    m_ready;

    logic             m_valid, m_last, busy;
    logic [WIDTH-1:0] m_data;
    logic [CH_W-1:0]  m_ch;
    logic [7:0]       overrun_cnt;

    logic             sat_valid, sat_last, sat_busy;
    logic [WIDTH-1:0] sat_data;
    logic [CH_W-1:0]  sat_ch;
    logic [1:0]       sat_overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    imu_frame_scheduler #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CH_W(CH_W), .DIV(DIV), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ch_en(ch_en), .ch_samples(ch_samples),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch), .m_last(m_last),
        .busy(busy), .overrun_cnt(overrun_cnt)
    );

    imu_frame_scheduler #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .CH_W(CH_W), .DIV(DIV), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .ch_en(ch_en), .ch_samples(ch_samples),
        .m_valid(sat_valid), .m_ready(m_ready), .m_data(sat_data), .m_ch(sat_ch), .m_last(sat_last),
        .busy(sat_busy), .overrun_cnt(sat_overrun)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic expect_word(input string tag, input int data, input int ch, input bit last);
        check({tag, ".valid"}, 32'(m_valid), 32'd1);
        check({tag, ".data"},  32'(m_data),  32'(data));
        check({tag, ".ch"},    32'(m_ch),    32'(ch));
        check({tag, ".last"},  32'(m_last),  32'(last));
    endtask

    // Holds reset for two cycles; the caller then releases it and raises enable in cycle 0.
    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b0;
        step();
        step();
    endtask

    task automatic start_run();
        rst_n  = 1'b1;
        enable = 1'b1;
        cyc    = 0;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        m_ready    = 1'b1;
        ch_en      = 3'b111;
        ch_samples = {16'd300, 16'd200, 16'd100};

        // 1. Reset state and basic frame
        do_reset();
        check("rst.valid", 32'(m_valid), 32'd0);
        check("rst.data",  32'(m_data), 32'd0);
        check("rst.ch",    32'(m_ch), 32'd0);
        check("rst.last",  32'(m_last), 32'd0);
        check("rst.busy",  32'(busy), 32'd0);
        check("rst.ovr",   32'(overrun_cnt), 32'd0);
        start_run();
        run_to(7);
        check("basic.pre_tick", 32'(m_valid), 32'd0);
        step(); expect_word("basic.w0", 100, 0, 1'b0);
        check("basic.busy", 32'(busy), 32'd1);
        step(); expect_word("basic.w1", 200, 1, 1'b0);
        step(); expect_word("basic.w2", 300, 2, 1'b1);
        step();
        check("basic.end_valid", 32'(m_valid), 32'd0);
        check("basic.end_busy",  32'(busy), 32'd0);

        // 2. Backpressure: m_ready low for cycles 8..11
        do_reset();
        m_ready = 1'b0;
        start_run();
        run_to(8);
        for (int k = 0; k < 4; k++) begin
            expect_word("bp.hold", 100, 0, 1'b0);
            step();
        end
        m_ready = 1'b1;
        expect_word("bp.w0", 100, 0, 1'b0);
        step(); expect_word("bp.w1", 200, 1, 1'b0);
        step(); expect_word("bp.w2", 300, 2, 1'b1);
        step();
        check("bp.end_valid", 32'(m_valid), 32'd0);
        check("bp.ovr", 32'(overrun_cnt), 32'd0);

        // 3a. Sparse mask skips ch1 with no bubble
        do_reset();
        ch_en = 3'b101;
        start_run();
        run_to(8);
        expect_word("sparse.w0", 100, 0, 1'b0);
        step(); expect_word("sparse.w2", 300, 2, 1'b1);
        step();
        check("sparse.end_valid", 32'(m_valid), 32'd0);

        // 3b. Empty mask: ticks produce nothing
        do_reset();
        ch_en = 3'b000;
        start_run();
        for (int k = 0; k < 3 * DIV; k++) begin
            step();
            check("empty.valid", 32'(m_valid), 32'd0);
        end
        check("empty.ovr", 32'(overrun_cnt), 32'd0);

        // 4a. Overrun: m_ready low for cycles 8..27, samples changed meanwhile
        do_reset();
        ch_en   = 3'b111;
        m_ready = 1'b0;
        start_run();
        run_to(10);
        ch_samples = {16'd7, 16'd7, 16'd7};
        run_to(28);
        m_ready = 1'b1;
        check("ovr.at_release", 32'(overrun_cnt), 32'd2);
        expect_word("ovr.w0", 100, 0, 1'b0);
        step(); expect_word("ovr.w1", 200, 1, 1'b0);
        step(); expect_word("ovr.w2", 300, 2, 1'b1);
        step();
        check("ovr.idle_valid", 32'(m_valid), 32'd0);
        step(); expect_word("ovr.next_w0", 7, 0, 1'b0);
        check("ovr.after", 32'(overrun_cnt), 32'd2);

        // 4b. Tick coinciding with the last handshake (cycle 15) is dropped
        do_reset();
        ch_samples = {16'd300, 16'd200, 16'd100};
        m_ready    = 1'b0;
        start_run();
        run_to(13);
        m_ready = 1'b1;
        expect_word("edge.w0", 100, 0, 1'b0);
        run_to(15);
        expect_word("edge.w2", 300, 2, 1'b1);
        step();
        check("edge.valid", 32'(m_valid), 32'd0);
        check("edge.ovr",   32'(overrun_cnt), 32'd1);
        run_to(23);
        check("edge.no_frame", 32'(m_valid), 32'd0);
        step(); expect_word("edge.next_w0", 100, 0, 1'b0);

        // 4c. Saturation of the 2-bit counter after 5 dropped ticks
        do_reset();
        m_ready = 1'b0;
        start_run();
        run_to(32);
        check("sat.cnt3",     32'(sat_overrun), 32'd3);
        check("sat.main3",    32'(overrun_cnt), 32'd3);
        run_to(48);
        check("sat.held",     32'(sat_overrun), 32'd3);
        check("sat.main5",    32'(overrun_cnt), 32'd5);
        check("sat.data",     32'(sat_data), 32'd100);
        m_ready = 1'b1;

        // 5. Reset during the ch1 word
        do_reset();
        start_run();
        run_to(9);
        expect_word("rmid.w1", 200, 1, 1'b0);
        rst_n = 1'b0;
        step();
        check("rmid.valid", 32'(m_valid), 32'd0);
        check("rmid.busy",  32'(busy), 32'd0);
        check("rmid.ovr",   32'(overrun_cnt), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            step();
            check("rmid.quiet", 32'(m_valid), 32'd0);
        end
        step(); expect_word("rmid.restart_w0", 100, 0, 1'b0);

        // 6. Snapshot isolation: samples and mask changed during SEND
        do_reset();
        start_run();
        run_to(8);
        ch_samples = {16'd9, 16'd9, 16'd9};
        ch_en      = 3'b011;
        expect_word("iso.w0", 100, 0, 1'b0);
        step(); expect_word("iso.w1", 200, 1, 1'b0);
        step(); expect_word("iso.w2", 300, 2, 1'b1);
        run_to(16);
        expect_word("iso.next_w0", 9, 0, 1'b0);
        step(); expect_word("iso.next_w1", 9, 1, 1'b1);
        step();
        check("iso.end_valid", 32'(m_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
